// File: rtl/vexec_issue_sequencer.sv
// vexec_issue_sequencer: splits one vector instruction into LANES-wide beats for the execution unit.
// Optional perf counters (perf_beats, perf_stall) exist only when VEXEC_SEQ_PERF_EN is defined.
module vexec_issue_sequencer #(
    parameter int unsigned LANES = 4,
    parameter int unsigned MAXVL = 64,
    parameter int unsigned OPW   = 8,
    parameter int unsigned REGW  = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [OPW-1:0]               instr_op,
    input  logic [REGW-1:0]              instr_vd,
    input  logic [REGW-1:0]              instr_vs1,
    input  logic [REGW-1:0]              instr_vs2,
    input  logic [$clog2(MAXVL+1)-1:0]   instr_vl,
    output logic                         eu_valid,
    input  logic                         eu_ready,
    output logic [OPW-1:0]               eu_op,
    output logic [REGW-1:0]              eu_vd,
    output logic [REGW-1:0]              eu_vs1,
    output logic [REGW-1:0]              eu_vs2,
    output logic [$clog2(MAXVL)-1:0]     eu_elem_base,
    output logic [LANES-1:0]             eu_lane_mask,
    output logic                         eu_last,
    input  logic                         eu_done,
    output logic                         seq_done,
`ifdef VEXEC_SEQ_PERF_EN
    output logic [31:0]                  perf_beats,
    output logic [31:0]                  perf_stall,
`endif
    output logic                         seq_busy
);

    localparam int unsigned VLW = $clog2(MAXVL + 1);
    localparam int unsigned BW  = $clog2(MAXVL);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]       state, state_n;
    logic [VLW-1:0]   rem, rem_n;
    logic [VLW-1:0]   eff_vl;
    logic [BW-1:0]    base_n;
    logic [LANES-1:0] mask_n;
    logic             last_n;
    logic             valid_n;
    logic             done_n;
    logic             accept;

    // Lanes below n are active; n >= LANES gives a full mask.
    function automatic logic [LANES-1:0] lane_mask(input logic [VLW-1:0] n);
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = (VLW'(i) < n);
        end
    endfunction

    assign eff_vl = (instr_vl > VLW'(MAXVL)) ? VLW'(MAXVL) : instr_vl;
    assign accept = (state == S_IDLE) && instr_valid;

    // rem holds the elements still to issue, including the beat currently presented.
    always_comb begin
        state_n = state;
        rem_n   = rem;
        base_n  = eu_elem_base;
        mask_n  = eu_lane_mask;
        last_n  = eu_last;
        valid_n = eu_valid;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    if (eff_vl != '0) begin
                        state_n = S_ISSUE;
                        valid_n = 1'b1;
                        base_n  = '0;
                        rem_n   = eff_vl;
                        mask_n  = lane_mask(eff_vl);
                        last_n  = (eff_vl <= VLW'(LANES));
                    end else begin
                        done_n  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (eu_ready) begin
                    if (eu_last) begin
                        state_n = S_WAIT;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                    end else begin
                        rem_n   = rem - VLW'(LANES);
                        base_n  = eu_elem_base + BW'(LANES);
                        mask_n  = lane_mask(rem_n);
                        last_n  = (rem_n <= VLW'(LANES));
                    end
                end
            end
            S_WAIT: begin
                if (eu_done) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rem          <= '0;
            instr_ready  <= 1'b1;
            seq_busy     <= 1'b0;
            seq_done     <= 1'b0;
            eu_valid     <= 1'b0;
            eu_last      <= 1'b0;
            eu_elem_base <= '0;
            eu_lane_mask <= '0;
            eu_op        <= '0;
            eu_vd        <= '0;
            eu_vs1       <= '0;
            eu_vs2       <= '0;
        end else begin
            state        <= state_n;
            rem          <= rem_n;
            instr_ready  <= (state_n == S_IDLE);
            seq_busy     <= (state_n != S_IDLE);
            seq_done     <= done_n;
            eu_valid     <= valid_n;
            eu_last      <= last_n;
            eu_elem_base <= base_n;
            eu_lane_mask <= mask_n;
            if (accept) begin
                eu_op  <= instr_op;
                eu_vd  <= instr_vd;
                eu_vs1 <= instr_vs1;
                eu_vs2 <= instr_vs2;
            end
        end
    end

`ifdef VEXEC_SEQ_PERF_EN
    // Saturating beat and stall counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_beats <= '0;
            perf_stall <= '0;
        end else begin
            if (eu_valid && eu_ready && (perf_beats != 32'hFFFF_FFFF)) begin
                perf_beats <= perf_beats + 32'd1;
            end
            if (eu_valid && !eu_ready && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vexec_issue_sequencer.sv
// Testbench for vexec_issue_sequencer: directed scenarios plus randomized instructions against a beat-list model.
module tb_vexec_issue_sequencer;

    localparam int LANES = 4;
    localparam int MAXVL = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_op;
    logic [4:0]  instr_vd, instr_vs1, instr_vs2;
    logic [6:0]  instr_vl;
    logic        eu_valid;
    logic        eu_ready;
    logic [7:0]  eu_op;
    logic [4:0]  eu_vd, eu_vs1, eu_vs2;
    logic [5:0]  eu_elem_base;
    logic [3:0]  eu_lane_mask;
    logic        eu_last;
    logic        eu_done;
    logic        seq_done;
    logic        seq_busy;
`ifdef VEXEC_SEQ_PERF_EN
    logic [31:0] perf_beats, perf_stall;
`endif

    int checks = 0;
    int errors = 0;
    int m_beats = 0;
    int m_stalls = 0;

    vexec_issue_sequencer #(.LANES(LANES), .MAXVL(MAXVL), .OPW(8), .REGW(5)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_vd(instr_vd), .instr_vs1(instr_vs1), .instr_vs2(instr_vs2),
        .instr_vl(instr_vl),
        .eu_valid(eu_valid), .eu_ready(eu_ready),
        .eu_op(eu_op), .eu_vd(eu_vd), .eu_vs1(eu_vs1), .eu_vs2(eu_vs2),
        .eu_elem_base(eu_elem_base), .eu_lane_mask(eu_lane_mask), .eu_last(eu_last),
        .eu_done(eu_done), .seq_done(seq_done),
`ifdef VEXEC_SEQ_PERF_EN
        .perf_beats(perf_beats), .perf_stall(perf_stall),
`endif
        .seq_busy(seq_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef VEXEC_SEQ_PERF_EN
        chk({tag, "_beats"}, perf_beats, m_beats);
        chk({tag, "_stall"}, perf_stall, m_stalls);
`else
        if (tag.len() == 0) $display("no tag");
`endif
    endtask

    // mode 0: eu_ready always high; 1: random with pct%; 2: stall 3 cycles on beat index 1
    task automatic run_instr(input int vl, input int mode, input int pct, input int done_dly,
                             input bit done_early);
        int eff, nb, k, cyc, stall;
        logic r;
        logic [7:0] op;
        logic [4:0] vd, vs1, vs2;
        logic [LANES-1:0] m;
        op  = 8'($urandom);
        vd  = 5'($urandom);
        vs1 = 5'($urandom);
        vs2 = 5'($urandom);
        eff = (vl > MAXVL) ? MAXVL : vl;
        nb  = (eff + LANES - 1) / LANES;
        chk("idle_ready", {instr_ready, seq_busy}, 2'b10);
        instr_valid = 1'b1;
        instr_op = op; instr_vd = vd; instr_vs1 = vs1; instr_vs2 = vs2;
        instr_vl = 7'(vl);
        @(negedge clk);
        instr_valid = 1'b0;
        instr_op = 8'($urandom);
        instr_vl = 7'($urandom);
        if (eff == 0) begin
            chk("vl0_done", {seq_done, instr_ready, eu_valid, seq_busy}, 4'b1100);
            @(negedge clk);
            chk("vl0_clear", {seq_done, eu_valid, instr_ready}, 3'b001);
            return;
        end
        k = 0; cyc = 0; stall = 0;
        while (k < nb && cyc < 4000) begin
            m = (k == nb - 1 && (eff % LANES) != 0) ? LANES'((1 << (eff % LANES)) - 1) : '1;
            chk("beat", {eu_valid, eu_last, eu_lane_mask, eu_elem_base},
                {1'b1, (k == nb - 1), m, 6'(k * LANES)});
            chk("payload", {eu_op, eu_vd, eu_vs1, eu_vs2}, {op, vd, vs1, vs2});
            chk("issue_flags", {instr_ready, seq_busy, seq_done}, 3'b010);
            case (mode)
                0: r = 1'b1;
                2: r = !(k == 1 && stall < 3);
                default: r = ($urandom_range(0, 99) < pct);
            endcase
            if (mode == 2 && !r) stall++;
            eu_ready = r;
            eu_done  = done_early ? ((k == nb - 1 && r) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
            if (r) begin
                k++;
                m_beats++;
            end else begin
                m_stalls++;
            end
            cyc++;
            @(negedge clk);
        end
        eu_done = 1'b0;
        if (k < nb) chk("beat_timeout", k, nb);
        for (int d = 0; d < done_dly; d++) begin
            chk("wait_state", {eu_valid, seq_done, seq_busy, instr_ready}, 4'b0010);
            eu_ready = 1'($urandom);
            @(negedge clk);
        end
        check_perf("perf");
        eu_done = 1'b1;
        eu_ready = 1'b0;
        @(negedge clk);
        eu_done = 1'b0;
        chk("seq_done", {seq_done, instr_ready, seq_busy, eu_valid}, 4'b1100);
        @(negedge clk);
        chk("seq_done_pulse", {seq_done, instr_ready}, 2'b01);
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0; instr_op = '0; instr_vd = '0; instr_vs1 = '0; instr_vs2 = '0;
        instr_vl = '0; eu_ready = 1'b0; eu_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_flags", {instr_ready, eu_valid, eu_last, seq_done, seq_busy}, 5'b10000);
        chk("rst_payload", {eu_op, eu_vd, eu_vs1, eu_vs2, eu_elem_base, eu_lane_mask}, 0);
        check_perf("rst_perf");
        reset = 1'b0;
        @(negedge clk);

        // vl=10 full throughput, eu_done two cycles after the last beat
        run_instr(10, 0, 100, 2, 1'b0);
        // vl=8 with a three-cycle stall on the second beat
        run_instr(8, 2, 100, 1, 1'b0);
        // vl=0: nothing issued
        run_instr(0, 0, 100, 0, 1'b0);
        // vl=100 clamps to MAXVL
        run_instr(100, 0, 100, 0, 1'b0);
        // eu_done during ISSUE and on the last-beat cycle must be ignored
        run_instr(9, 1, 60, 2, 1'b1);

        // reset after the first beat of vl=12
        chk("rst_idle_ready", instr_ready, 1'b1);
        instr_valid = 1'b1; instr_vl = 7'd12; instr_op = 8'h5A;
        @(negedge clk);
        instr_valid = 1'b0;
        eu_ready = 1'b1;
        chk("rst_b0", {eu_valid, eu_elem_base}, {1'b1, 6'd0});
        @(negedge clk);
        chk("rst_b1", {eu_valid, eu_elem_base}, {1'b1, 6'd4});
        reset = 1'b1;
        eu_ready = 1'b0;
        m_beats = 0;
        m_stalls = 0;
        @(negedge clk);
        chk("rst_mid", {instr_ready, eu_valid, seq_busy, seq_done, eu_last}, 5'b10000);
        chk("rst_mid_base", {eu_elem_base, eu_lane_mask}, 0);
        check_perf("rst_mid_perf");
        reset = 1'b0;
        eu_done = 1'b1;
        @(negedge clk);
        eu_done = 1'b0;
        chk("rst_no_done", {seq_done, instr_ready, eu_valid}, 3'b010);
        run_instr(12, 0, 100, 1, 1'b0);

        // randomized instructions
        repeat (30) begin
            run_instr($urandom_range(0, 80), 1, $urandom_range(30, 100),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
